key_evt_arbiter: RTL and testbench
==================================

Name: key_evt_arbiter

Overview:
- Shares one downstream command channel (LED/mode sequencer) between N debounced keys.
- Latches each key's single-cycle press pulse as a pending request and grants pending keys round-robin over a valid/ready handshake.
- Enforces a programmable hold-off gap between grants.
- Sits between the per-key debouncers and the LED control logic.

Parameters:
- N_KEYS, 4, number of requesting keys (2..16).
- GAP_CYC, 100000, hold-off cycles after each accepted grant (0 = no gap).
- ID_W, $clog2(N_KEYS), width of the event id (derived; not overridden).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- key_cap_i  in  N_KEYS  per-key press pulse, synchronous to clk_i, one cycle per press
- evt_valid_o  out  1  grant valid
- evt_id_o  out  ID_W  granted key index
- evt_ready_i  in  1  consumer accepts the event when high together with evt_valid_o
- pend_o  out  N_KEYS  current pending flags (observation)
- busy_o  out  1  high in GRANT or GAP state

Behaviour:
- Reset (async assert, sync release): state=IDLE, pend=0, evt_valid_o=0, evt_id_o=0, busy_o=0, last_grant=N_KEYS-1 so key 0 has first priority, gap counter=0.
- Pending: pend[i] sets on any cycle with key_cap_i[i]=1.
  - pend[i] clears on the accept cycle (evt_valid_o & evt_ready_i) when evt_id_o==i.
  - If a set and a clear hit the same bit in the same cycle, the set wins and pend[i] stays 1.
  - A second pulse while pend[i]=1 is merged; no queueing per key.
- Round-robin pick (combinational): first set bit of pend, searching from last_grant+1 upward with wrap to 0. With no pend bits set there is no pick.
- FSM:
  - IDLE: if pend≠0, register the pick into evt_id_o, set evt_valid_o=1, go to GRANT. Otherwise stay.
  - GRANT: evt_valid_o and evt_id_o held stable until accepted; a new key_cap_i pulse never changes them.
    - On accept: evt_valid_o=0 next cycle, last_grant=evt_id_o, clear pend[evt_id_o].
    - Then, if GAP_CYC==0, go to IDLE; else load counter=GAP_CYC-1 and go to GAP.
  - GAP: decrement each cycle; at counter==0 go to IDLE. Pulses arriving in GAP are still latched.
- Latency: pulse in cycle t with FSM in IDLE -> pend visible in t+1 -> evt_valid_o high in t+2.
- Grant spacing with ready tied high = GAP_CYC+2 cycles: 1 GRANT + GAP_CYC GAP + 1 IDLE.
- evt_ready_i is ignored when evt_valid_o=0.
- Reset asserted mid-GRANT or mid-GAP: all outputs drop to reset values immediately; the pending event is lost.
- Counter width is $clog2(GAP_CYC+1), minimum 1 bit.

Optional Feature:
- Macro: KEY_ARB_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o, width N_KEYS*8, with slice i = key i.
  - Each slice is an 8-bit saturating counter (max 255) of pulses merged because pend[i] was already 1 and not cleared that cycle.
  - Reset value 0.
- Not defined: no counters and no drop_cnt_o port; merged pulses are silently dropped.

Decomposition:
- Package key_arb_pkg:
  - FSM state enum (IDLE, GRANT, GAP)
  - DROP_CNT_W=8 constant
  - default GAP constant
- Sub-module key_rr_pick: purely combinational.
  - Inputs: pend, last_grant.
  - Outputs: pick_vld, pick_id.
  - Instantiated once.

Test Plan:
- Single press, N_KEYS=4, GAP_CYC=2: pulse key_cap_i=4'b0100 at t, ready=1 -> evt_valid_o=1 with evt_id_o=2 at t+2 only; pend_o returns to 0 at t+3; busy_o high t+2..t+4.
- Simultaneous pulses 4'b1011 at t, ready=1 -> grants in id order 0,1,3 at t+2, t+6, t+10; pend_o=0 after the last accept.
- Backpressure: ready=0 for 10 cycles during a grant of id 1 -> valid/id stable throughout. Another key 1 pulse during the wait leaves pend_o[1]=1, and with KEY_ARB_DROP_CNT_EN drop_cnt_o[15:8]=1.
- Round-robin wrap: last_grant=3, pend=4'b0101 -> next id 0, then 2.
- Same-cycle set/clear: key 1 pulse in the accept cycle of id 1 -> pend_o[1] stays 1; a second grant of id 1 follows after the gap.
- Async reset: assert rst_i mid-GRANT (between clock edges) -> evt_valid_o, pend_o, busy_o go to 0 before the next edge. After release, a pulse on key 3 gives evt_id_o=3 with normal 2-cycle latency.

Source files
------------

// File: rtl/key_arb_pkg.sv
// rtl/key_arb_pkg.sv - shared types and constants for the key event arbiter
package key_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DROP_CNT_W      = 8;
  localparam int DEFAULT_GAP_CYC = 100000;

endpackage

// File: rtl/key_rr_pick.sv
// rtl/key_rr_pick.sv - combinational round-robin pick starting after last_grant
module key_rr_pick #(
  parameter int N_KEYS = 4,
  parameter int ID_W   = $clog2(N_KEYS)
) (
  input  logic [N_KEYS-1:0] pend,
  input  logic [ID_W-1:0]   last_grant,
  output logic              pick_vld,
  output logic [ID_W-1:0]   pick_id
);

  // Scan from farthest to nearest so the closest set bit after last_grant wins.
  always_comb begin
    pick_vld = |pend;
    pick_id  = '0;
    for (int k = N_KEYS; k >= 1; k--) begin
      if (pend[(int'(last_grant) + k) % N_KEYS]) begin
        pick_id = ID_W'((int'(last_grant) + k) % N_KEYS);
      end
    end
  end

endmodule

// File: rtl/key_evt_arbiter.sv
// rtl/key_evt_arbiter.sv - round-robin arbiter of key press events onto one channel
// Optional per-key merged-pulse counters (drop_cnt_o) when KEY_ARB_DROP_CNT_EN is defined.
module key_evt_arbiter
  import key_arb_pkg::*;
#(
  parameter int   N_KEYS  = 4,
  parameter int   GAP_CYC = DEFAULT_GAP_CYC,
  localparam int  ID_W    = $clog2(N_KEYS)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_KEYS-1:0]                key_cap_i,
  output logic                             evt_valid_o,
  output logic [ID_W-1:0]                  evt_id_o,
  input  logic                             evt_ready_i,
`ifdef KEY_ARB_DROP_CNT_EN
  output logic [N_KEYS*DROP_CNT_W-1:0]     drop_cnt_o,
`endif
  output logic [N_KEYS-1:0]                pend_o,
  output logic                             busy_o
);

  localparam int CNT_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  arb_state_t        state, state_n;
  logic [N_KEYS-1:0] pend, pend_n, clr;
  logic              valid_n;
  logic [ID_W-1:0]   id_n;
  logic [ID_W-1:0]   last_grant, last_grant_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;
  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;

  key_rr_pick #(
    .N_KEYS (N_KEYS),
    .ID_W   (ID_W)
  ) u_pick (
    .pend       (pend),
    .last_grant (last_grant),
    .pick_vld   (pick_vld),
    .pick_id    (pick_id)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pend        <= '0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      last_grant  <= ID_W'(N_KEYS - 1);
      cnt         <= '0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      evt_valid_o <= valid_n;
      evt_id_o    <= id_n;
      last_grant  <= last_grant_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    valid_n      = evt_valid_o;
    id_n         = evt_id_o;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    accept       = evt_valid_o & evt_ready_i;
    clr          = '0;
    if (accept) clr[evt_id_o] = 1'b1;
    // A new press in the accept cycle re-arms the key rather than being lost.
    pend_n = (pend & ~clr) | key_cap_i;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          id_n    = pick_id;
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          valid_n      = 1'b0;
          last_grant_n = evt_id_o;
          if (GAP_CYC == 0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = CNT_W'(GAP_CYC - 1);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pend_o = pend;
  assign busy_o = (state == GRANT) || (state == GAP);

`ifdef KEY_ARB_DROP_CNT_EN
  logic [N_KEYS-1:0][DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_cap_i[i] && pend[i] && !clr[i] && (drop_cnt[i] != '1)) begin
          drop_cnt[i] <= drop_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

endmodule

// File: tb/tb_key_evt_arbiter.sv
// tb/tb_key_evt_arbiter.sv - directed self-checking bench for key_evt_arbiter
module tb_key_evt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_cap;
  logic       ready;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pend;
  logic       busy;
`ifdef KEY_ARB_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  key_evt_arbiter #(
    .N_KEYS  (4),
    .GAP_CYC (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_cap_i   (key_cap),
    .evt_valid_o (valid),
    .evt_id_o    (id),
    .evt_ready_i (ready),
`ifdef KEY_ARB_DROP_CNT_EN
    .drop_cnt_o  (drop_cnt),
`endif
    .pend_o      (pend),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_cap = '0;
    ready   = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst_valid", valid, 0);
    check("rst_id", id, 0);
    check("rst_pend", pend, 0);
    check("rst_busy", busy, 0);
`ifdef KEY_ARB_DROP_CNT_EN
    check("rst_drop", drop_cnt, 0);
`endif

    // simultaneous presses 1011: grants 0,1,3 at t+2, t+6, t+10
    key_cap = 4'b1011;
    step();
    key_cap = '0;
    check("multi_pend_t1", pend, 4'b1011);
    for (int c = 2; c <= 11; c++) begin
      step();
      check($sformatf("multi_valid_t%0d", c), valid, (c == 2 || c == 6 || c == 10));
      if (c == 2 || c == 6 || c == 10)
        check($sformatf("multi_id_t%0d", c), id, (c == 2) ? 0 : (c == 6) ? 1 : 3);
    end
    check("multi_pend_end", pend, 0);
    step(2);
    check("multi_idle_busy", busy, 0);

    // wrap: last_grant=3, pend 0101 -> 0 then 2
    key_cap = 4'b0101;
    step();
    key_cap = '0;
    step();
    check("wrap_v0", valid, 1);
    check("wrap_id0", id, 0);
    step(4);
    check("wrap_v1", valid, 1);
    check("wrap_id1", id, 2);
    step(3);

    // single press key 2
    key_cap = 4'b0100;
    step();
    key_cap = '0;
    check("single_pend_t1", pend, 4'b0100);
    check("single_valid_t1", valid, 0);
    check("single_busy_t1", busy, 0);
    step();
    check("single_valid_t2", valid, 1);
    check("single_id_t2", id, 2);
    check("single_busy_t2", busy, 1);
    step();
    check("single_valid_t3", valid, 0);
    check("single_pend_t3", pend, 0);
    check("single_busy_t3", busy, 1);
    step();
    check("single_busy_t4", busy, 1);
    step();
    check("single_busy_t5", busy, 0);

    // backpressure on id 1 with a merged second press
    ready   = 1'b0;
    key_cap = 4'b0010;
    step();
    key_cap = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), valid, 1);
      check($sformatf("bp_id_%0d", i), id, 1);
      key_cap = (i == 2) ? 4'b0010 : 4'b0000;
      step();
    end
    key_cap = '0;
    check("bp_pend_merged", pend, 4'b0010);
`ifdef KEY_ARB_DROP_CNT_EN
    check("bp_drop1", drop_cnt[15:8], 1);
`endif
    ready = 1'b1;
    step();
    check("bp_valid_after", valid, 0);
    check("bp_pend_after", pend, 0);
    step(2);

    // press of key 1 in its own accept cycle re-arms it
    key_cap = 4'b0010;
    step();
    key_cap = '0;
    step();
    check("sc_valid_t2", valid, 1);
    check("sc_id_t2", id, 1);
    key_cap = 4'b0010;
    step();
    key_cap = '0;
    check("sc_pend_t3", pend, 4'b0010);
    check("sc_valid_t3", valid, 0);
    step(3);
    check("sc_valid_t6", valid, 1);
    check("sc_id_t6", id, 1);
`ifdef KEY_ARB_DROP_CNT_EN
    check("sc_drop_unchanged", drop_cnt[15:8], 1);
`endif
    step();
    check("sc_pend_t7", pend, 0);
    step(2);

    // async reset mid-GRANT
    ready   = 1'b0;
    key_cap = 4'b0100;
    step();
    key_cap = 4'b0010;
    step();
    key_cap = '0;
    check("ar_valid_pre", valid, 1);
    check("ar_id_pre", id, 2);
    check("ar_pend_pre", pend, 4'b0110);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", valid, 0);
    check("ar_pend", pend, 0);
    check("ar_busy", busy, 0);
    check("ar_id", id, 0);
`ifdef KEY_ARB_DROP_CNT_EN
    check("ar_drop", drop_cnt, 0);
`endif
    #2;
    rst = 1'b0;
    step();
    ready   = 1'b1;
    key_cap = 4'b1000;
    step();
    key_cap = '0;
    check("post_pend_t1", pend, 4'b1000);
    check("post_valid_t1", valid, 0);
    step();
    check("post_valid_t2", valid, 1);
    check("post_id_t2", id, 3);
    step();
    check("post_valid_t3", valid, 0);
    check("post_pend_t3", pend, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
